// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the parallel-in serial-out datapath.
package shift_reg_pkg;

    // Serializer control states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bits needed to hold a bit index in the range 0..width-1 (at least one bit).
    function automatic int CNT_W(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable, synchronous clear and a terminal-count flag.
// The count wraps from MOD-1 back to 0 on an enabled cycle.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         tc;

    assign tc = (count_q == W'(MOD - 1));

    // Next count: clear has priority over enable; wrap at the terminal count.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc ? '0 : count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc;

endmodule : mod_counter

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts one WIDTH-bit word per valid/ready handshake
// and shifts it out one bit per shift_en cycle, flagging the final bit. A new word
// can be taken on the last bit of the current one, so words stream with no gap.
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   parallel_in,
    input  logic               shift_en,
    output logic               serial_out,
    output logic               serial_valid,
    output logic               serial_last,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count
);

    localparam int BC_W = CNT_W(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_shifted;
    logic [COUNT_W-1:0] word_count_q;

    logic [BC_W-1:0]    bit_cnt;
    logic               bit_tc;
    logic               in_shift;
    logic               last_bit;
    logic               accept;
    logic               out_bit;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift & (bit_cnt == BC_W'(WIDTH - 1));

    // Ready while idle, or on the enabled last bit so the next word follows without a gap.
    // Held low while reset is asserted so nothing is offered before release.
    assign in_ready = reset_n & (~in_shift | (shift_en & last_bit));
    assign accept   = in_valid & in_ready;

    // Bit index within the current word: counts enabled shift cycles, parked at 0 while idle.
    mod_counter #(
        .MOD (WIDTH),
        .W   (BC_W)
    ) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (in_shift & shift_en),
        .clr_i   (~in_shift),
        .count_o (bit_cnt),
        .tc_o    (bit_tc)
    );

    // Move one position toward the output end, zero-filling behind.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign out_bit       = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign out_bit       = shreg_q[0];
        end
    endgenerate

    // Control FSM, shift register and completed-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= parallel_in;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (bit_tc) begin
                            word_count_q <= word_count_q + COUNT_W'(1);
                            if (in_valid) begin
                                shreg_q <= parallel_in;
                            end else begin
                                shreg_q <= '0;
                                state_q <= IDLE;
                            end
                        end else begin
                            shreg_q <= shreg_shifted;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from register state; serial_out is forced low when idle.
    assign serial_out   = in_shift & out_bit;
    assign serial_valid = in_shift;
    assign busy         = in_shift;
    assign serial_last  = last_bit;
    assign word_count   = word_count_q;

endmodule : piso_serializer
